// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code decoder.
//   ps2_state_t : prefix FSM states (IDLE, EXT = E0 seen, BRK = F0 seen,
//                 EXT_BRK = E0 F0 seen)
//   PFX_EXT/BRK : Set-2 prefix bytes
//   ps2_evt_t   : queued key event {code, brk, ext}
//   is_ctrl()   : keyboard control/status bytes that never form key events
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_evt_t;

    // Error/ack/BAT bytes the keyboard sends outside of key traffic.
    function automatic logic is_ctrl(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word-fall-through queue of key events.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_push/i_data : write request and event
//   i_pop         : consume head (ignored when empty)
//   o_head        : current head event (valid when !o_empty)
//   o_full/o_empty: occupancy flags
// A push on full is accepted only when a pop frees the slot in the same cycle.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_push,
    input  ps2_evt_t i_data,
    input  logic     i_pop,
    output ps2_evt_t o_head,
    output logic     o_full,
    output logic     o_empty
);
    localparam int AW = $clog2(DEPTH);

    ps2_evt_t    r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd[AW-1:0]];

    // Storage is reset so the head reads as all-zero straight out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr[AW-1:0]] <= i_data;
                r_wr                <= r_wr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) r_rd <= r_rd + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: turns validated PS/2 Set-2 bytes into key events.
//   CLOCK_50, RESET         : clock, asynchronous active-high reset
//   CODE_VALID/BYTE/ERR     : one-cycle byte strobe from the PS/2 receiver
//   EVT_VALID/READY         : FWFT event queue handshake
//   EVT_CODE/BREAK/EXT      : head event (code, release flag, E0 flag)
//   SPACE_HELD, FLAP        : space level and single-cycle press pulse
//   OVERFLOW                : sticky, an event was dropped on a full queue
// Build option: define PS2_EXTENDED_EN to decode E0-prefixed keys; without it
// E0 is discarded and extended keys alias onto their base codes.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 4,
    parameter logic [7:0] SPACE_CODE     = 8'h29,
    parameter int         PREFIX_TIMEOUT = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       CODE_VALID,
    input  logic [7:0] CODE_BYTE,
    input  logic       CODE_ERR,
    output logic       EVT_VALID,
    input  logic       EVT_READY,
    output logic [7:0] EVT_CODE,
    output logic       EVT_BREAK,
    output logic       EVT_EXT,
    output logic       SPACE_HELD,
    output logic       FLAP,
    output logic       OVERFLOW
);
`ifdef PS2_EXTENDED_EN
    localparam logic EXT_EN = 1'b1;
`else
    localparam logic EXT_EN = 1'b0;
`endif
    localparam int            CW      = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(PREFIX_TIMEOUT - 1);

    ps2_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_held;
    logic          r_flap;
    logic          r_ovf;

    ps2_state_t    w_next;
    logic          w_push;
    ps2_evt_t      w_evt;
    ps2_evt_t      w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_space;

    // Byte decode: next prefix state and whether this byte completes a key.
    always_comb begin
        w_next     = r_state;
        w_push     = 1'b0;
        w_evt.code = CODE_BYTE;
        w_evt.brk  = 1'b0;
        w_evt.ext  = 1'b0;
        if (CODE_VALID) begin
            if (CODE_ERR) begin
                w_next = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (CODE_BYTE == PFX_BRK)      w_next = ST_BRK;
`ifdef PS2_EXTENDED_EN
                        else if (CODE_BYTE == PFX_EXT) w_next = ST_EXT;
`else
                        else if (CODE_BYTE == PFX_EXT) w_next = ST_IDLE;
`endif
                        else if (!is_ctrl(CODE_BYTE))  w_push = 1'b1;
                    end
`ifdef PS2_EXTENDED_EN
                    ST_EXT: begin
                        if (CODE_BYTE == PFX_BRK)      w_next = ST_EXT_BRK;
                        else if (CODE_BYTE != PFX_EXT) begin
                            w_push    = 1'b1;
                            w_evt.ext = 1'b1;
                            w_next    = ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        w_next = ST_IDLE;
                        if (CODE_BYTE != PFX_EXT && CODE_BYTE != PFX_BRK) begin
                            w_push    = 1'b1;
                            w_evt.brk = 1'b1;
                            w_evt.ext = 1'b1;
                        end
                    end
`endif
                    ST_BRK: begin
                        // A second prefix after F0 is a protocol error: drop it.
                        w_next = ST_IDLE;
                        if (CODE_BYTE != PFX_EXT && CODE_BYTE != PFX_BRK) begin
                            w_push    = 1'b1;
                            w_evt.brk = 1'b1;
                        end
                    end
                    default: w_next = ST_IDLE;
                endcase
            end
        end
    end

    assign w_space = w_push && !w_evt.ext && (w_evt.code == SPACE_CODE);
    assign w_pop   = EVT_READY && !w_empty;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
            r_flap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (CODE_VALID) begin
                r_cnt   <= '0;
                r_state <= w_next;
            end else if (r_state != ST_IDLE) begin
                // A stalled prefix gives up so a lost byte cannot flip the
                // meaning of the next key.
                if (r_cnt == TO_LAST) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end

            // Typematic repeats arrive as presses while already held: no FLAP.
            r_flap <= 1'b0;
            if (w_space) begin
                if (w_evt.brk) begin
                    r_held <= 1'b0;
                end else begin
                    r_held <= 1'b1;
                    r_flap <= !r_held;
                end
            end

            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (CLOCK_50),
        .i_rst   (RESET),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_pop   (EVT_READY),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign EVT_VALID  = !w_empty;
    assign EVT_CODE   = w_head.code;
    assign EVT_BREAK  = w_head.brk;
    assign EVT_EXT    = w_head.ext & EXT_EN;
    assign SPACE_HELD = r_held;
    assign FLAP       = r_flap;
    assign OVERFLOW   = r_ovf;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
module tb_ps2_scan_decoder;

`ifdef PS2_EXTENDED_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif
    localparam int DEPTH = 4;
    localparam int TMO   = 40;

    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b1;
    logic       CODE_VALID = 1'b0;
    logic [7:0] CODE_BYTE = 8'h00;
    logic       CODE_ERR = 1'b0;
    logic       EVT_READY = 1'b0;
    logic       EVT_VALID, EVT_BREAK, EVT_EXT, SPACE_HELD, FLAP, OVERFLOW;
    logic [7:0] EVT_CODE;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_scan_decoder #(.FIFO_DEPTH(DEPTH), .SPACE_CODE(8'h29), .PREFIX_TIMEOUT(TMO)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .CODE_VALID(CODE_VALID), .CODE_BYTE(CODE_BYTE),
        .CODE_ERR(CODE_ERR), .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_CODE(EVT_CODE),
        .EVT_BREAK(EVT_BREAK), .EVT_EXT(EVT_EXT), .SPACE_HELD(SPACE_HELD), .FLAP(FLAP),
        .OVERFLOW(OVERFLOW)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: pending-prefix flags, event queue {code,brk,ext}, space state.
    logic [9:0] m_q[$];
    bit m_e0, m_f0, m_held, m_flap, m_ovf;
    int m_idle, m_flaps;

    function automatic bit tb_ctrl(input logic [7:0] b);
        logic [7:0] lst [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
        foreach (lst[i]) if (lst[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_e0 = 0; m_f0 = 0; m_held = 0; m_flap = 0; m_ovf = 0; m_idle = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] b, input bit e, input bit rdy);
        bit push = 0;
        logic [9:0] ev = '0;
        m_flap = 0;
        if (v) begin
            m_idle = 0;
            if (e) begin m_e0 = 0; m_f0 = 0; end
            else if (b == 8'hE0) begin
                if (m_f0) begin m_e0 = 0; m_f0 = 0; end
                else if (EXT_EN) m_e0 = 1;
            end else if (b == 8'hF0) begin
                if (m_f0) begin m_e0 = 0; m_f0 = 0; end
                else m_f0 = 1;
            end else if (!m_e0 && !m_f0 && tb_ctrl(b)) begin
                push = 0;
            end else begin
                push = 1; ev = {b, m_f0, m_e0};
                m_e0 = 0; m_f0 = 0;
            end
        end else if (m_e0 || m_f0) begin
            m_idle++;
            if (m_idle >= TMO) begin m_e0 = 0; m_f0 = 0; end
        end
        if (push && ev[0] == 1'b0 && ev[9:2] == 8'h29) begin
            if (ev[1]) m_held = 0;
            else begin m_flap = !m_held; m_held = 1; end
        end
        if (m_flap) m_flaps++;
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else m_ovf = 1;
        end
    endtask

    // One clock: drive at negedge, model the edge, return at next negedge.
    task automatic cyc(input bit v, input logic [7:0] b, input bit e, input bit rdy);
        CODE_VALID = v; CODE_BYTE = b; CODE_ERR = e; EVT_READY = rdy;
        @(posedge CLOCK_50);
        model_edge(v, b, e, rdy);
        @(negedge CLOCK_50);
        CODE_VALID = 0; CODE_ERR = 0; EVT_READY = 0;
    endtask

    task automatic do_reset();
        RESET = 1;
        @(negedge CLOCK_50);
        model_clear();
        RESET = 0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        @(negedge CLOCK_50);
        n_cmp++;
        if ({EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT, SPACE_HELD, FLAP, OVERFLOW} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b%h%b%b%b%b%b want all zero",
                     EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT, SPACE_HELD, FLAP, OVERFLOW);
        end
        model_clear();
        RESET = 0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_space();
        logic [7:0] seq [3] = '{8'h29, 8'hF0, 8'h29};
        int fl = 0, got = 0;
        do_reset();
        foreach (seq[i]) begin
            cyc(1, seq[i], 0, 0);
            fl += FLAP;
            n_cmp++;
            if ({FLAP, SPACE_HELD} !== {m_flap, m_held}) begin
                n_bad++;
                $display("FAIL space_flap_held[%0d]: got %b%b want %b%b", i, FLAP, SPACE_HELD, m_flap, m_held);
            end
            cyc(0, 8'h00, 0, 0);
            fl += FLAP;
        end
        n_cmp++;
        if (fl != 1) begin n_bad++; $display("FAIL space_flap_count: got %0d want 1", fl); end
        for (int k = 0; k < 8 && m_q.size() > 0; k++) begin
            n_cmp++;
            if ({EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT} !== {1'b1, m_q[0]}) begin
                n_bad++;
                $display("FAIL space_evt[%0d]: got %b %h %b %b want 1 %h %b %b", k, EVT_VALID, EVT_CODE,
                         EVT_BREAK, EVT_EXT, m_q[0][9:2], m_q[0][1], m_q[0][0]);
            end
            got++;
            cyc(0, 8'h00, 0, 1);
        end
        n_cmp++;
        if (EVT_VALID !== 1'b0 || got != 2) begin
            n_bad++; $display("FAIL space_drain: valid %b events %0d want 0 and 2", EVT_VALID, got);
        end
    endtask

    task automatic test_typematic();
        logic [7:0] seq [5] = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29};
        int fl = 0, got = 0;
        do_reset();
        foreach (seq[i]) begin
            cyc(1, seq[i], 0, 0);   // back-to-back strobes
            fl += FLAP;
        end
        cyc(0, 8'h00, 0, 0);
        fl += FLAP;
        n_cmp++;
        if (fl != 1 || SPACE_HELD !== 1'b0) begin
            n_bad++; $display("FAIL typematic_flap: got flaps %0d held %b want 1 and 0", fl, SPACE_HELD);
        end
        for (int k = 0; k < 8 && m_q.size() > 0; k++) begin
            n_cmp++;
            if ({EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT} !== {1'b1, m_q[0]}) begin
                n_bad++;
                $display("FAIL typematic_evt[%0d]: got %h %b %b want %h %b %b", k, EVT_CODE, EVT_BREAK,
                         EVT_EXT, m_q[0][9:2], m_q[0][1], m_q[0][0]);
            end
            got++;
            cyc(0, 8'h00, 0, 1);
        end
        n_cmp++;
        if (EVT_VALID !== 1'b0 || got != 4) begin
            n_bad++; $display("FAIL typematic_drain: valid %b events %0d want 0 and 4", EVT_VALID, got);
        end
    endtask

    task automatic test_extended();
        logic [7:0] seq [7] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h29};
        logic [9:0] want [3];
        want[0] = {8'h75, 1'b0, EXT_EN};
        want[1] = {8'h75, 1'b1, EXT_EN};
        want[2] = {8'h29, 1'b0, EXT_EN};
        do_reset();
        foreach (seq[i]) cyc(1, seq[i], 0, 0);
        n_cmp++;
        // E0 29 is space only when extended decoding is off.
        if (SPACE_HELD !== !EXT_EN || FLAP !== !EXT_EN) begin
            n_bad++; $display("FAIL ext_space_alias: got held %b flap %b want %b", SPACE_HELD, FLAP, !EXT_EN);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT} !== {1'b1, want[k]}) begin
                n_bad++;
                $display("FAIL ext_evt[%0d]: got %b %h %b %b want 1 %h %b %b", k, EVT_VALID, EVT_CODE,
                         EVT_BREAK, EVT_EXT, want[k][9:2], want[k][1], want[k][0]);
            end
            cyc(0, 8'h00, 0, 1);
        end
        n_cmp++;
        if (EVT_VALID !== 1'b0) begin n_bad++; $display("FAIL ext_drain: got valid %b want 0", EVT_VALID); end
    endtask

    task automatic test_timeout();
        do_reset();
        // Gap one short of the limit: prefix still applies.
        cyc(1, 8'hF0, 0, 0);
        repeat (TMO - 1) cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h1C, 0, 0);
        // Gap of the full limit: prefix abandoned.
        cyc(1, 8'hF0, 0, 0);
        repeat (TMO) cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h1C, 0, 0);
        n_cmp++;
        if ({EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT} !== {1'b1, 8'h1C, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL timeout_before: got %h brk %b want 1c brk 1", EVT_CODE, EVT_BREAK);
        end
        cyc(0, 8'h00, 0, 1);
        n_cmp++;
        if ({EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL timeout_after: got v %b %h brk %b want 1c brk 0", EVT_VALID, EVT_CODE, EVT_BREAK);
        end
        cyc(0, 8'h00, 0, 1);
        n_cmp++;
        if (EVT_VALID !== 1'b0) begin n_bad++; $display("FAIL timeout_drain: got valid %b want 0", EVT_VALID); end
    endtask

    task automatic test_overflow();
        logic [7:0] keys [7] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B};
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, keys[i], 0, 0);
        // Push while full but popping: both happen, no overflow.
        cyc(1, keys[4], 0, 1);
        n_cmp++;
        if (OVERFLOW !== 1'b0 || EVT_CODE !== m_q[0][9:2]) begin
            n_bad++; $display("FAIL ovf_push_pop: got ovf %b head %h want 0 %h", OVERFLOW, EVT_CODE, m_q[0][9:2]);
        end
        cyc(1, keys[5], 0, 0);
        cyc(1, keys[6], 0, 0);
        n_cmp++;
        if (OVERFLOW !== 1'b1 || OVERFLOW !== m_ovf) begin
            n_bad++; $display("FAIL ovf_sticky: got %b want 1", OVERFLOW);
        end
        for (int k = 0; k < DEPTH; k++) begin
            n_cmp++;
            if ({EVT_VALID, EVT_CODE, EVT_BREAK} !== {1'b1, keys[k + 1], 1'b0}) begin
                n_bad++; $display("FAIL ovf_order[%0d]: got %b %h want 1 %h", k, EVT_VALID, EVT_CODE, keys[k + 1]);
            end
            cyc(0, 8'h00, 0, 1);
        end
        n_cmp++;
        if (EVT_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
            n_bad++; $display("FAIL ovf_drain: got valid %b ovf %b want 0 1", EVT_VALID, OVERFLOW);
        end
    endtask

    task automatic test_err_and_reset();
        do_reset();
        cyc(1, 8'hF0, 1, 0);   // errored prefix is dropped
        cyc(1, 8'h29, 0, 0);
        n_cmp++;
        if ({EVT_VALID, EVT_CODE, EVT_BREAK, FLAP, SPACE_HELD} !== {1'b1, 8'h29, 1'b0, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL err_discard: got %b %h brk %b flap %b held %b want 1 29 0 1 1",
                              EVT_VALID, EVT_CODE, EVT_BREAK, FLAP, SPACE_HELD);
        end
        cyc(1, 8'h1C, 0, 0);
        cyc(1, 8'hE0, 0, 0);
        cyc(1, 8'hF0, 0, 0);
        #2 RESET = 1;
        #1;
        n_cmp++;
        if ({EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT, SPACE_HELD, FLAP, OVERFLOW} !== 14'd0) begin
            n_bad++; $display("FAIL reset_async: got v %b code %h held %b want all zero", EVT_VALID, EVT_CODE, SPACE_HELD);
        end
        @(negedge CLOCK_50);
        model_clear();
        RESET = 0;
        @(negedge CLOCK_50);
        cyc(1, 8'h29, 0, 0);
        n_cmp++;
        if ({EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT, FLAP} !== {1'b1, 8'h29, 1'b0, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL reset_prefix_gone: got %h brk %b ext %b flap %b want 29 0 0 1",
                              EVT_CODE, EVT_BREAK, EVT_EXT, FLAP);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pool [10] = '{8'h29, 8'hF0, 8'hE0, 8'h1C, 8'h75, 8'hAA, 8'h00, 8'h29, 8'hF0, 8'h5A};
        int nf = 0;
        do_reset();
        m_flaps = 0;
        for (int c = 0; c < 600; c++) begin
            bit v = ($urandom_range(3) != 0);
            bit e = ($urandom_range(15) == 0);
            bit r = $urandom_range(1);
            logic [7:0] b = ($urandom_range(7) == 0) ? 8'($urandom) : pool[$urandom_range(9)];
            if (c % 150 == 149) repeat (TMO + 2) cyc(0, 8'h00, 0, 0);
            cyc(v, b, e, r);
            nf += FLAP;
            n_cmp++;
            if ({EVT_VALID, SPACE_HELD, FLAP, OVERFLOW} !== {m_q.size() > 0, m_held, m_flap, m_ovf}) begin
                n_bad++; $display("FAIL b2b_flags[%0d]: got %b%b%b%b want %b%b%b%b", c, EVT_VALID, SPACE_HELD,
                                  FLAP, OVERFLOW, m_q.size() > 0, m_held, m_flap, m_ovf);
            end
            if (m_q.size() > 0) begin
                n_cmp++;
                if ({EVT_CODE, EVT_BREAK, EVT_EXT} !== m_q[0]) begin
                    n_bad++; $display("FAIL b2b_head[%0d]: got %h %b %b want %h %b %b", c, EVT_CODE,
                                      EVT_BREAK, EVT_EXT, m_q[0][9:2], m_q[0][1], m_q[0][0]);
                end
            end
        end
        n_cmp++;
        if (nf != m_flaps) begin n_bad++; $display("FAIL b2b_flap_total: got %0d want %0d", nf, m_flaps); end
    endtask

    initial begin
        test_reset();
        test_space();
        test_typematic();
        test_extended();
        test_timeout();
        test_overflow();
        test_err_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Downstream consumer of the PS/2 byte receiver: takes validated scan-code bytes, resolves Set-2 make/break (0xF0) and extended (0xE0) prefixes, and queues complete key events for game logic through a valid/ready FIFO. Also tracks the space bar directly, exposing a held level and a single-cycle FLAP pulse with typematic repeats suppressed, so the bird controller no longer needs a latched KEY_PRESSED.

## Interface
- FIFO_DEPTH, 4: event queue entries; power of two, ≥2.
- SPACE_CODE, 8'h29: make code tracked for SPACE_HELD/FLAP.
- PREFIX_TIMEOUT, 1_000_000: CLOCK_50 cycles (20 ms) a prefix state may wait for its next byte.
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CODE_VALID  in  1  one-cycle strobe: CODE_BYTE/CODE_ERR valid.
- CODE_BYTE  in  8  received data byte.
- CODE_ERR  in  1  parity/framing error for this byte; sampled only with CODE_VALID.
- EVT_VALID  out  1  FIFO head holds an event.
- EVT_READY  in  1  consumer accepts head when EVT_VALID & EVT_READY.
- EVT_CODE  out  8  key code of head event.
- EVT_BREAK  out  1  1 = release, 0 = press.
- EVT_EXT  out  1  event was E0-prefixed.
- SPACE_HELD  out  1  space currently down.
- FLAP  out  1  one-cycle pulse on space press transition.
- OVERFLOW  out  1  sticky: event dropped because FIFO full.

## Operation
- Reset: FSM IDLE, FIFO empty, timeout counter 0; EVT_VALID, SPACE_HELD, FLAP, OVERFLOW = 0; EVT_CODE = 0, EVT_BREAK = 0, EVT_EXT = 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Only CODE_VALID strobes advance it.
- IDLE: E0→EXT; F0→BRK; control bytes 00, AA, EE, FA, FC, FE, FF discarded; any other byte → press event {code, break=0, ext=0}.
- EXT: F0→EXT_BRK; E0 stays EXT; other → press event ext=1, to IDLE.
- BRK: other → release event ext=0, to IDLE; E0/F0 → protocol error, discard, to IDLE.
- EXT_BRK: other → release event ext=1, to IDLE; E0/F0 → discard, to IDLE.
- CODE_ERR=1 with CODE_VALID: byte discarded, FSM to IDLE from any state, no event.
- Timeout: counter runs in any non-IDLE state, clears on every CODE_VALID; reaching PREFIX_TIMEOUT−1 forces IDLE, no event.
- Space tracking (ext=0, code=SPACE_CODE): press with SPACE_HELD=0 → SPACE_HELD=1, FLAP pulse; press with SPACE_HELD=1 (typematic) → no FLAP; release → SPACE_HELD=0. Independent of FIFO state; still updates when event is dropped.
- FIFO: first-word-fall-through. Push on full without simultaneous pop → event dropped, OVERFLOW=1 until reset. Push and pop same cycle on full → both occur, no overflow. Pop on empty ignored.

## Timing
- Final byte sampled on edge n (CODE_VALID high in cycle n−1→n): event written, SPACE_HELD updated, FLAP high for exactly cycle after edge n.
- EVT_VALID rises after edge n when FIFO was empty (1-cycle latency); EVT_* change only on a pop or empty→non-empty push.
- Back-to-back CODE_VALID on consecutive cycles fully supported.
- RESET mid-sequence or mid-FIFO discards all pending state asynchronously; outputs at reset values immediately.

## Configuration
- PS2_EXTENDED_EN defined: EXT/EXT_BRK states exist; EVT_EXT reports prefix; E0-prefixed keys never match SPACE_CODE.
- Undefined: E0 discarded as a control byte in IDLE, FSM only IDLE/BRK, EVT_EXT tied 0; extended keys alias to base codes (e.g. E0 29 reported as space).

## Structure
- Package ps2_pkg: FSM state enum, prefix constants (8'hE0, 8'hF0), control-byte list, packed event struct {code[7:0], brk, ext}.
- Sub-module ps2_event_fifo: parameterized FWFT FIFO of event structs, push/pop/full/empty, pointer wrap via log2 depth + extra bit.

## Test plan
- Bytes 29, F0 29 -> events {29,press,ext0}, {29,release,ext0}; FLAP once after first 29; SPACE_HELD 1 then 0.
- 29 29 29 (typematic) then F0 29 -> three press events + release; exactly one FLAP pulse.
- E0 75, E0 F0 75 (defined macro) -> {75,press,ext1}, {75,release,ext1}; undefined -> ext=0 both.
- F0 then idle PREFIX_TIMEOUT cycles, then 1C -> single {1C,press}, no release event.
- EVT_READY=0, five key presses with FIFO_DEPTH=4 -> four queued in order, OVERFLOW=1; then drain returns first four.
- F0 with CODE_ERR=1, then 29 -> FSM in IDLE, {29,press}; RESET asserted mid E0 F0 -> all outputs 0 immediately.
